// File: rtl/wb_bus_pkg.sv
// Shared types for the multi-master Wishbone interconnect.
package wb_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_MISS   = 2'd2
  } bus_state_e;

  // Low bit of slot idx inside a packed vector of width-sized slots.
  function automatic int unsigned slot_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: first requester scanning upward from (ptr_i + 1) mod NUM_REQ.
module wb_rr_arbiter
  import wb_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  int unsigned cand;
  logic        found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_bus_mm.sv
// Multi-master Wishbone interconnect: round-robin grant, mask/value slave decode,
// error response for unmapped addresses and a per-transaction watchdog.
module wb_bus_mm
  import wb_bus_pkg::*;
#(
  parameter int unsigned             WB_DATA_WIDTH  = 8,
  parameter int unsigned             WB_ADDR_WIDTH  = 16,
  parameter int unsigned             WB_NUM_MASTERS = 2,
  parameter int unsigned             WB_NUM_SLAVES  = 4,
  parameter int unsigned             TIMEOUT_BITS   = 6,
  parameter logic [WB_DATA_WIDTH-1:0] DEFAULT_DATA  = 8'hFF
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_stb_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_we_i,
  input  logic [WB_NUM_MASTERS*WB_ADDR_WIDTH-1:0] mstr_adr_i,
  input  logic [WB_NUM_MASTERS*WB_DATA_WIDTH-1:0] mstr_dat_i,
  output logic [WB_NUM_MASTERS-1:0]               mstr_ack_o,
  output logic [WB_NUM_MASTERS-1:0]               mstr_err_o,
  output logic [WB_NUM_MASTERS*WB_DATA_WIDTH-1:0] mstr_dat_o,
  input  logic [WB_NUM_SLAVES*WB_ADDR_WIDTH-1:0]  bus_slv_addr_decode_value,
  input  logic [WB_NUM_SLAVES*WB_ADDR_WIDTH-1:0]  bus_slv_addr_decode_mask,
  output logic [WB_NUM_SLAVES-1:0]                slv_stb_o,
  output logic [WB_NUM_SLAVES-1:0]                slv_we_o,
  output logic [WB_NUM_SLAVES*WB_ADDR_WIDTH-1:0]  slv_adr_o,
  output logic [WB_NUM_SLAVES*WB_DATA_WIDTH-1:0]  slv_dat_o,
  input  logic [WB_NUM_SLAVES-1:0]                slv_ack_i,
  input  logic [WB_NUM_SLAVES*WB_DATA_WIDTH-1:0]  slv_dat_i,
  output logic                                    busy_o
);

  localparam int unsigned AW = WB_ADDR_WIDTH;
  localparam int unsigned DW = WB_DATA_WIDTH;
  localparam int unsigned IW = (WB_NUM_MASTERS > 1) ? $clog2(WB_NUM_MASTERS) : 1;
  localparam int unsigned SW = (WB_NUM_SLAVES > 1) ? $clog2(WB_NUM_SLAVES) : 1;
  localparam logic [TIMEOUT_BITS-1:0] CNT_MAX = '1;

  bus_state_e              state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           gidx_q, gidx_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;

  logic [WB_NUM_MASTERS-1:0] arb_gnt;
  logic [IW-1:0]             arb_idx;
  logic [AW-1:0]             req_adr;
  logic                      dec_hit;
  logic [SW-1:0]             dec_sel;

  wb_rr_arbiter #(
    .NUM_REQ (WB_NUM_MASTERS),
    .IDX_W   (IW)
  ) u_arb (
    .req_i     (mstr_stb_i),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  // Descending scan so the lowest matching slot wins on overlapping windows.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    req_adr = mstr_adr_i[slot_lo(32'(arb_idx), AW) +: AW];
    for (int i = WB_NUM_SLAVES - 1; i >= 0; i--) begin
      if ((req_adr & bus_slv_addr_decode_mask[i*AW +: AW]) == bus_slv_addr_decode_value[i*AW +: AW]) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(WB_NUM_MASTERS - 1);
      gidx_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          gidx_d  = arb_idx;
          ptr_d   = arb_idx;
          sel_d   = dec_sel;
          cnt_d   = '0;
          state_d = dec_hit ? ST_ACTIVE : ST_MISS;
        end
      end
      ST_ACTIVE: begin
        if (!mstr_stb_i[gidx_q] || (cnt_q == CNT_MAX) || slv_ack_i[sel_q]) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_BITS'(1);
        end
      end
      ST_MISS: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe is withdrawn in the watchdog cycle, so an ack seen then is stale.
  always_comb begin
    mstr_ack_o = '0;
    mstr_err_o = '0;
    mstr_dat_o = '0;
    slv_stb_o  = '0;
    slv_we_o   = '0;
    slv_adr_o  = '0;
    slv_dat_o  = '0;
    case (state_q)
      ST_ACTIVE: begin
        slv_we_o[sel_q] = mstr_we_i[gidx_q];
        slv_adr_o[slot_lo(32'(sel_q), AW) +: AW] = mstr_adr_i[slot_lo(32'(gidx_q), AW) +: AW];
        slv_dat_o[slot_lo(32'(sel_q), DW) +: DW] = mstr_dat_i[slot_lo(32'(gidx_q), DW) +: DW];
        if (mstr_stb_i[gidx_q]) begin
          if (cnt_q == CNT_MAX) begin
            mstr_ack_o[gidx_q] = 1'b1;
            mstr_err_o[gidx_q] = 1'b1;
            mstr_dat_o[slot_lo(32'(gidx_q), DW) +: DW] = DEFAULT_DATA;
          end else begin
            slv_stb_o[sel_q] = 1'b1;
            if (slv_ack_i[sel_q]) begin
              mstr_ack_o[gidx_q] = 1'b1;
              mstr_dat_o[slot_lo(32'(gidx_q), DW) +: DW] = slv_dat_i[slot_lo(32'(sel_q), DW) +: DW];
            end
          end
        end
      end
      ST_MISS: begin
        mstr_ack_o[gidx_q] = 1'b1;
        mstr_err_o[gidx_q] = 1'b1;
        mstr_dat_o[slot_lo(32'(gidx_q), DW) +: DW] = DEFAULT_DATA;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule
